// File: rtl/amp_pwr_seq_pkg.sv
// amp_pwr_seq_pkg: shared state encoding and defaults for the amp sequencer.
// Used by amp_pwr_seq and amp_gain_scl.
package amp_pwr_seq_pkg;

    typedef enum logic [2:0] {
        SHDN    = 3'd0,
        RAMP_UP = 3'd1,
        RUN     = 3'd2,
        RAMP_DN = 3'd3,
        MUTED   = 3'd4,
        FAULT   = 3'd5,
        LOCKOUT = 3'd6
    } amp_state_t;

    localparam int AMP_GAIN_W = 6;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/amp_gain_scl.sv
// amp_gain_scl: one audio channel, registered signed sample times mute gain.
// Output loads only on vld; gain is an unsigned fraction with GAIN_W bits.
module amp_gain_scl
    import amp_pwr_seq_pkg::*;
#(
    parameter int GAIN_W = AMP_GAIN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_i,
    input  logic [GAIN_W:0]    gain_i,
    input  logic signed [15:0] din_i,
    output logic signed [15:0] dout_o
);

    localparam int PW = 17 + GAIN_W;

    logic signed [PW-1:0] din_x;
    logic signed [PW-1:0] gain_x;
    logic signed [PW-1:0] prod;
    logic [15:0]          dout_d;
    logic [15:0]          dout_q;
    logic                 unused_bits;

    assign din_x  = $signed({{(GAIN_W + 1){din_i[15]}}, din_i});
    assign gain_x = $signed({16'd0, gain_i});
    assign prod   = din_x * gain_x;

    // Arithmetic shift by GAIN_W then keep 16 bits == this slice.
    assign dout_d      = prod[GAIN_W +: 16];
    assign unused_bits = ^{prod[PW-1], prod[GAIN_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (vld_i) begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/amp_pwr_seq.sv
// amp_pwr_seq: class-D amp power-up, fault retry/lockout and soft-mute gain.
// Optional lifetime fault counter port flt_cnt: define AMP_PWR_SEQ_FLT_CNT_EN.
module amp_pwr_seq
    import amp_pwr_seq_pkg::*;
#(
    parameter int STARTUP_CYC = 250000,
    parameter int RETRY_CYC   = 1000000,
    parameter int MAX_RETRY   = 3,
    parameter int GAIN_W      = AMP_GAIN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Flt_n,
    input  logic               mute_req,
    input  logic               vld,
    input  logic signed [15:0] aud_in_lft,
    input  logic signed [15:0] aud_in_rght,
    output logic signed [15:0] aud_out_lft,
    output logic signed [15:0] aud_out_rght,
    output logic               out_vld,
    output logic               sht_dwn,
    output amp_state_t         amp_state,
    output logic               locked
`ifdef AMP_PWR_SEQ_FLT_CNT_EN
    ,
    output logic [7:0]         flt_cnt
`endif
);

    localparam int TMR_W = $clog2(max_i(STARTUP_CYC, RETRY_CYC) + 1);
    localparam int RC_W  = $clog2(MAX_RETRY + 1);

    localparam logic [GAIN_W:0] GAIN_MAX = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] GAIN_ONE = {{GAIN_W{1'b0}}, 1'b1};

    amp_state_t      state_q, state_d;
    logic [GAIN_W:0] gain_q, gain_d, gain_use;
    logic [GAIN_W:0] gain_inc, gain_dec;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RC_W-1:0] retry_q, retry_d;
    logic            sync1_q, flt_s_q;
    logic            out_vld_q;
    logic            fault;

    assign fault = !flt_s_q && !(state_q inside {SHDN, FAULT, LOCKOUT});

    assign gain_inc = (gain_q == GAIN_MAX) ? GAIN_MAX : gain_q + GAIN_ONE;
    assign gain_dec = (gain_q == '0) ? '0 : gain_q - GAIN_ONE;

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        gain_use = gain_q;
        if (fault) begin
            state_d  = FAULT;
            gain_d   = '0;
            timer_d  = '0;
            retry_d  = retry_q + RC_W'(1);
            gain_use = '0;
        end else begin
            unique case (state_q)
                SHDN: begin
                    gain_d = '0;
                    if (!flt_s_q) begin
                        timer_d = '0;
                    end else if (timer_q == TMR_W'(STARTUP_CYC - 1)) begin
                        timer_d = '0;
                        state_d = RAMP_UP;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                RAMP_UP: begin
                    if (vld) gain_d = gain_inc;
                    if (mute_req) begin
                        state_d = RAMP_DN;
                    end else if (gain_d == GAIN_MAX) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    gain_d = GAIN_MAX;
                    if (mute_req) state_d = RAMP_DN;
                end
                RAMP_DN: begin
                    if (vld) gain_d = gain_dec;
                    if (!mute_req) begin
                        state_d = RAMP_UP;
                    end else if (gain_d == '0) begin
                        state_d = MUTED;
                    end
                end
                MUTED: begin
                    gain_d = '0;
                    if (!mute_req) state_d = RAMP_UP;
                end
                FAULT: begin
                    gain_d = '0;
                    if (retry_q == RC_W'(MAX_RETRY)) begin
                        state_d = LOCKOUT;
                    end else if (!flt_s_q) begin
                        timer_d = '0;
                    end else if (timer_q == TMR_W'(RETRY_CYC - 1)) begin
                        timer_d = '0;
                        state_d = SHDN;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                LOCKOUT: begin
                    gain_d = '0;
                end
                default: begin
                    state_d = SHDN;
                    gain_d  = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            flt_s_q   <= 1'b1;
            state_q   <= SHDN;
            gain_q    <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            sync1_q   <= Flt_n;
            flt_s_q   <= sync1_q;
            state_q   <= state_d;
            gain_q    <= gain_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            out_vld_q <= vld;
        end
    end

`ifdef AMP_PWR_SEQ_FLT_CNT_EN
    logic [7:0] flt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt_q <= '0;
        end else if (fault && flt_cnt_q != 8'hFF) begin
            flt_cnt_q <= flt_cnt_q + 8'd1;
        end
    end

    assign flt_cnt = flt_cnt_q;
`endif

    amp_gain_scl #(.GAIN_W(GAIN_W)) u_scl_lft (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (vld),
        .gain_i (gain_use),
        .din_i  (aud_in_lft),
        .dout_o (aud_out_lft)
    );

    amp_gain_scl #(.GAIN_W(GAIN_W)) u_scl_rght (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (vld),
        .gain_i (gain_use),
        .din_i  (aud_in_rght),
        .dout_o (aud_out_rght)
    );

    assign out_vld   = out_vld_q;
    assign sht_dwn   = state_q inside {SHDN, FAULT, LOCKOUT};
    assign amp_state = state_q;
    assign locked    = (state_q == LOCKOUT);

endmodule

// File: tb/tb_amp_pwr_seq.sv
// tb_amp_pwr_seq: directed bench, scoreboard on out_vld plus state checks.
// Small timing parameters keep sequences short.
`timescale 1ns/1ps
module tb_amp_pwr_seq;
    import amp_pwr_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Flt_n = 1'b1;
    logic        mute_req = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] aud_in_lft = '0;
    logic [15:0] aud_in_rght = '0;
    logic [15:0] aud_out_lft;
    logic [15:0] aud_out_rght;
    logic        out_vld;
    logic        sht_dwn;
    amp_state_t  amp_state;
    logic        locked;
`ifdef AMP_PWR_SEQ_FLT_CNT_EN
    logic [7:0]  flt_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    amp_pwr_seq #(
        .STARTUP_CYC (20),
        .RETRY_CYC   (10),
        .MAX_RETRY   (3),
        .GAIN_W      (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Flt_n        (Flt_n),
        .mute_req     (mute_req),
        .vld          (vld),
        .aud_in_lft   (aud_in_lft),
        .aud_in_rght  (aud_in_rght),
        .aud_out_lft  (aud_out_lft),
        .aud_out_rght (aud_out_rght),
        .out_vld      (out_vld),
        .sht_dwn      (sht_dwn),
        .amp_state    (amp_state),
        .locked       (locked)
`ifdef AMP_PWR_SEQ_FLT_CNT_EN
        ,
        .flt_cnt      (flt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_vld) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h_%h, expected none",
                         aud_out_lft, aud_out_rght);
            end else begin
                chk("aud_out", {aud_out_lft, aud_out_rght}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] el, input logic [15:0] er);
        vld = 1'b1;
        aud_in_lft = l;
        aud_in_rght = r;
        exp_q.push_back({el, er});
        wait_cyc(1);
        vld = 1'b0;
    endtask

    task automatic ramp(input int g0, input int dir, input int n);
        for (int k = 0; k < n; k++) begin
            int g;
            g = g0 + dir * k;
            send(16'h4000, 16'hC000, 16'(g * 256), 16'(-(g * 256)));
        end
    endtask

    task automatic wait_state(input amp_state_t s, input int budget);
        int n;
        n = 0;
        while (amp_state != s && n < budget) begin
            wait_cyc(1);
            n++;
        end
        chk($sformatf("wait_%s", s.name()), amp_state, s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
    endtask

    task automatic fault_pulse();
        Flt_n = 1'b0;
        wait_cyc(1);
        Flt_n = 1'b1;
        wait_cyc(2);
        chk("fault_state", amp_state, FAULT);
        chk("fault_shdn", sht_dwn, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        wait_cyc(3);
        chk("rst_state", amp_state, SHDN);
        chk("rst_shdn", sht_dwn, 1'b1);
        chk("rst_locked", locked, 1'b0);
        chk("rst_out", {out_vld, aud_out_lft, aud_out_rght}, 33'd0);
`ifdef AMP_PWR_SEQ_FLT_CNT_EN
        chk("rst_flt_cnt", flt_cnt, 8'd0);
`endif
        rst = 1'b0;

        // power-up delay then 64-step ramp
        ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
            wait_cyc(1);
            if (sht_dwn !== 1'b1) ok = 1'b0;
        end
        chk("pwrup_hold", ok, 1'b1);
        wait_cyc(1);
        chk("pwrup_shdn", sht_dwn, 1'b0);
        chk("pwrup_state", amp_state, RAMP_UP);
        ramp(0, 1, 64);
        chk("ramp_run", amp_state, RUN);
        send(16'h4000, 16'hC000, 16'h4000, 16'hC000);
        send(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);

        // full mute and back up
        mute_req = 1'b1;
        wait_cyc(1);
        chk("mute_rampdn", amp_state, RAMP_DN);
        ramp(64, -1, 64);
        chk("mute_muted", amp_state, MUTED);
        chk("mute_shdn", sht_dwn, 1'b0);
        send(16'h4000, 16'hC000, 16'h0000, 16'h0000);
        mute_req = 1'b0;
        wait_cyc(1);
        chk("unmute_up", amp_state, RAMP_UP);
        ramp(0, 1, 64);
        chk("unmute_run", amp_state, RUN);

        // mute on a vld edge uses RUN step, then partial ramp-down
        mute_req = 1'b1;
        send(16'h4000, 16'hC000, 16'h4000, 16'hC000);
        chk("mute_vld_state", amp_state, RAMP_DN);
        ramp(64, -1, 10);
        mute_req = 1'b0;
        wait_cyc(1);
        chk("part_up", amp_state, RAMP_UP);
        ramp(54, 1, 10);
        chk("part_run", amp_state, RUN);

        // fault latency from RUN
        Flt_n = 1'b0;
        wait_cyc(1);
        Flt_n = 1'b1;
        chk("flt_lat1", sht_dwn, 1'b0);
        wait_cyc(1);
        chk("flt_lat2", sht_dwn, 1'b0);
        wait_cyc(1);
        chk("flt_lat3", sht_dwn, 1'b1);
        chk("flt_state", amp_state, FAULT);
        wait_cyc(9);
        chk("flt_hold", amp_state, FAULT);
        wait_cyc(1);
        chk("flt_retry", amp_state, SHDN);
        wait_cyc(19);
        chk("flt_shdn_hold", sht_dwn, 1'b1);
        wait_cyc(1);
        chk("flt_restart", amp_state, RAMP_UP);

        // fault coinciding with vld
        ramp(0, 1, 5);
        Flt_n = 1'b0;
        wait_cyc(1);
        Flt_n = 1'b1;
        wait_cyc(1);
        send(16'h4000, 16'hC000, 16'h0000, 16'h0000);
        chk("flt_vld_state", amp_state, FAULT);

        // glitch in SHDN restarts the startup count
        wait_state(SHDN, 30);
        wait_cyc(5);
        Flt_n = 1'b0;
        wait_cyc(1);
        Flt_n = 1'b1;
        wait_cyc(21);
        chk("glitch_hold", amp_state, SHDN);
        wait_cyc(1);
        chk("glitch_exit", amp_state, RAMP_UP);

        // reset mid-FAULT clears retry count
        do_reset();
        wait_state(RAMP_UP, 30);
        fault_pulse();
        wait_state(SHDN, 15);
        wait_state(RAMP_UP, 30);
        fault_pulse();
        do_reset();
        chk("rst_mid_flt", amp_state, SHDN);

        // three faults before RUN -> lockout
        for (int f = 0; f < 3; f++) begin
            wait_state(RAMP_UP, 30);
            fault_pulse();
            if (f < 2) wait_state(SHDN, 15);
        end
        wait_cyc(1);
        chk("lock_state", amp_state, LOCKOUT);
        chk("lock_locked", locked, 1'b1);
        chk("lock_shdn", sht_dwn, 1'b1);
        send(16'h4000, 16'hC000, 16'h0000, 16'h0000);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_cyc(1);
            if (locked !== 1'b1) ok = 1'b0;
        end
        chk("lock_sticky", ok, 1'b1);
        do_reset();
        chk("lock_rst_state", amp_state, SHDN);
        chk("lock_rst_locked", locked, 1'b0);

`ifdef AMP_PWR_SEQ_FLT_CNT_EN
        do_reset();
        chk("cnt_clear", flt_cnt, 8'd0);
        for (int f = 0; f < 300; f++) begin
            wait_state(RAMP_UP, 30);
            ramp(0, 1, 64);
            fault_pulse();
            if (f == 0) chk("cnt_one", flt_cnt, 8'd1);
        end
        chk("cnt_sat", flt_cnt, 8'd255);
`endif

        wait_cyc(3);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
